neuron_config_loader: RTL

//  Host-side driver for the neuron weight/bias load bus. Accepts a flat valid/ready word stream from the AXI

---
 rtl/neuron_config_loader.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/neuron_config_loader.sv
// neuron_config_loader
//   Streams weight/bias words from a valid/ready source onto the neuron load
//   bus, tagging each word with its target layer/neuron number.
//   Walk order: layer-major, then neuron-major; per neuron NUM_WEIGHTS weights
//   followed by one bias.
//   Optional build macro: CFG_CHECKSUM_EN adds a 32-bit running sum of all
//   accepted words on port checksum.
module neuron_config_loader #(
   parameter int DATA_WIDTH   = 16,
   parameter int NUM_LAYERS   = 1,
   parameter int NUM_NEURONS  = 128,
   parameter int NUM_WEIGHTS  = 128,
   parameter int FIRST_LAYER  = 1,
   parameter int FIRST_NEURON = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [DATA_WIDTH-1:0]   s_data,
   output logic                    weightValid,
   output logic                    biasValid,
   output logic [DATA_WIDTH-1:0]   weightValue,
   output logic [DATA_WIDTH-1:0]   biasValue,
   output logic [2*DATA_WIDTH:0]   config_layer_num,
   output logic [2*DATA_WIDTH:0]   config_neuron_num,
   output logic                    busy,
   output logic                    done
`ifdef CFG_CHECKSUM_EN
   ,
   output logic [31:0]             checksum
`endif
);

   localparam int AW = 2*DATA_WIDTH+1;
   localparam int LW = (NUM_LAYERS  > 1) ? $clog2(NUM_LAYERS)  : 1;
   localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
   localparam int WW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WEIGHT = 2'd1;
   localparam logic [1:0] S_BIAS   = 2'd2;
   localparam logic [1:0] S_FINISH = 2'd3;

   logic [1:0]            r_state;
   logic [LW-1:0]         r_l;
   logic [NW-1:0]         r_n;
   logic [WW-1:0]         r_w;
   logic                  r_weight_valid;
   logic                  r_bias_valid;
   logic [DATA_WIDTH-1:0] r_weight_value;
   logic [DATA_WIDTH-1:0] r_bias_value;
   logic [AW-1:0]         r_layer_num;
   logic [AW-1:0]         r_neuron_num;
   logic                  r_done;

   logic                  w_hs;
   logic [AW-1:0]         w_layer_addr;
   logic [AW-1:0]         w_neuron_addr;

   // Words are only taken while walking weights or bias; no downstream stall.
   assign s_ready       = (r_state == S_WEIGHT) || (r_state == S_BIAS);
   assign w_hs          = s_valid & s_ready;
   assign w_layer_addr  = AW'(FIRST_LAYER)  + AW'(r_l);
   assign w_neuron_addr = AW'(FIRST_NEURON) + AW'(r_n);

   assign busy              = (r_state != S_IDLE);
   assign done              = r_done;
   assign weightValid       = r_weight_valid;
   assign biasValid         = r_bias_valid;
   assign weightValue       = r_weight_value;
   assign biasValue         = r_bias_value;
   assign config_layer_num  = r_layer_num;
   assign config_neuron_num = r_neuron_num;

   // Load-walk FSM: counters, one-cycle-latency output registers and done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_l            <= '0;
         r_n            <= '0;
         r_w            <= '0;
         r_weight_valid <= 1'b0;
         r_bias_valid   <= 1'b0;
         r_weight_value <= '0;
         r_bias_value   <= '0;
         r_layer_num    <= '0;
         r_neuron_num   <= '0;
         r_done         <= 1'b0;
      end else begin
         r_weight_valid <= 1'b0;
         r_bias_valid   <= 1'b0;
         r_done         <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_WEIGHT;
                  r_l     <= '0;
                  r_n     <= '0;
                  r_w     <= '0;
               end
            end
            S_WEIGHT: begin
               if (w_hs) begin
                  r_weight_valid <= 1'b1;
                  r_weight_value <= s_data;
                  r_layer_num    <= w_layer_addr;
                  r_neuron_num   <= w_neuron_addr;
                  if (r_w == WW'(NUM_WEIGHTS-1)) begin
                     r_w     <= '0;
                     r_state <= S_BIAS;
                  end else begin
                     r_w <= r_w + 1'b1;
                  end
               end
            end
            S_BIAS: begin
               if (w_hs) begin
                  r_bias_valid <= 1'b1;
                  r_bias_value <= s_data;
                  r_layer_num  <= w_layer_addr;
                  r_neuron_num <= w_neuron_addr;
                  r_w          <= '0;
                  if (r_n != NW'(NUM_NEURONS-1)) begin
                     r_n     <= r_n + 1'b1;
                     r_state <= S_WEIGHT;
                  end else if (r_l != LW'(NUM_LAYERS-1)) begin
                     r_n     <= '0;
                     r_l     <= r_l + 1'b1;
                     r_state <= S_WEIGHT;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_FINISH: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef CFG_CHECKSUM_EN
   logic [31:0] r_checksum;
   assign checksum = r_checksum;

   // Running modulo-2^32 sum of accepted words; cleared when a new load starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_checksum <= '0;
      end else if ((r_state == S_IDLE) && start) begin
         r_checksum <= '0;
      end else if (w_hs) begin
         r_checksum <= r_checksum + 32'(s_data);
      end
   end
`endif

endmodule
